// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - four-digit seven-segment scan controller with frame-aligned content swap
// Optional: DISPLAY_SCAN_DIM_EN adds the bright[1:0] dimming input.
module display_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        onoff,
    input  logic        load,
    input  logic [27:0] seg_in,
    input  logic [3:0]  dp_in,
`ifdef DISPLAY_SCAN_DIM_EN
    input  logic [1:0]  bright,
`endif
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        pending,
    output logic        frame_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK == 0) ? 0 : BLANK - 1);

    typedef enum logic [1:0] {S_OFF, S_BLANK, S_SHOW} state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   active_q, active_d;
    logic [31:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          frame_end;
    logic          commit;
    logic          lit;

    assign frame_end = (state_q == S_SHOW) && (idx_q == 2'd3) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        commit    = 1'b0;
        case (state_q)
            S_OFF: begin
                idx_d  = 2'd0;
                cnt_d  = '0;
                commit = pending_q;
                if (onoff) begin
                    state_d = (BLANK == 0) ? S_SHOW : S_BLANK;
                end
            end
            S_BLANK: begin
                if (!onoff) begin
                    state_d = S_OFF;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_SHOW;
                    end
                end
            end
            S_SHOW: begin
                commit = pending_q && frame_end;
                if (!onoff) begin
                    state_d = S_OFF;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 1'b1;
                    state_d = (BLANK == 0) ? S_SHOW : S_BLANK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_OFF;
        endcase
        // A load on the commit edge still leaves fresh data pending.
        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = {dp_in, seg_in};
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_OFF;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            active_q  <= '1;
            shadow_q  <= '1;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

`ifdef DISPLAY_SCAN_DIM_EN
    // bright is registered so no input reaches an output combinationally.
    logic [1:0]  bright_q;
    logic [31:0] lit_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            bright_q <= 2'd3;
        end else begin
            bright_q <= bright;
        end
    end

    always_comb begin
        lit_len = 32'(DIV - BLANK) >> (2'd3 - bright_q);
        lit     = (state_q == S_SHOW) && ((32'(cnt_q) - 32'(BLANK)) < lit_len);
    end
`else
    assign lit = (state_q == S_SHOW);
`endif

    always_comb begin
        an         = 4'hF;
        seg        = 7'h7F;
        dp         = 1'b1;
        if (lit) begin
            an  = ~(4'b0001 << idx_q);
            seg = active_q[7*int'(idx_q) +: 7];
            dp  = active_q[28 + int'(idx_q)];
        end
        pending    = pending_q;
        frame_tick = frame_end;
    end

endmodule
